// File: rtl/vector_instruction_queue_if.sv
// Handshake bundle between the scalar vector-issue port and the dispatch stage,
// including the queue's occupancy status.
interface vector_instruction_queue_if #(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int DEPTH            = 8
);
  logic                          push_valid;
  logic [DATA_FROM_SCALAR-1:0]   push_data;
  logic                          push_ready;
  logic                          flush;
  logic [DATA_FROM_SCALAR-1:0]   instruction;
  logic                          valid_fifo;
  logic                          ready;
  logic [$clog2(DEPTH):0]        count;
  logic                          full;
  logic                          empty;

  modport master (
    output push_valid, push_data, flush, ready,
    input  push_ready, instruction, valid_fifo, count, full, empty
  );

  modport slave (
    input  push_valid, push_data, flush, ready,
    output push_ready, instruction, valid_fifo, count, full, empty
  );
endinterface

// File: rtl/vector_instruction_queue.sv
// DEPTH-entry first-word-fall-through FIFO buffering vector instruction packets
// from the scalar core ahead of vector dispatch.
module vector_instruction_queue #(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int DEPTH            = 8
) (
  input logic                      clk,
  input logic                      rst,
  vector_instruction_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_FROM_SCALAR-1:0] mem [DEPTH];
  logic [PTR_W-1:0]            rd_ptr;
  logic [PTR_W-1:0]            wr_ptr;
  logic [CNT_W-1:0]            count_q;
  logic                        full_w;
  logic                        empty_w;
  logic                        push_fire;
  logic                        pop_fire;

  // Status decodes use registered state only, so push_ready never depends on ready.
  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign push_fire = q.push_valid & ~full_w;
  assign pop_fire  = q.ready & ~empty_w;

  assign q.push_ready  = ~full_w;
  assign q.valid_fifo  = ~empty_w;
  assign q.instruction = empty_w ? '0 : mem[rd_ptr];
  assign q.count       = count_q;
  assign q.full        = full_w;
  assign q.empty       = empty_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (q.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= q.push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
